// File: rtl/inv_deser_pkg.sv
// Shared definitions for the inverter-output bit deserializer.
package inv_deser_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } deser_state_t;

endpackage

// File: rtl/inv_bit_deserializer_if.sv
// Serial-bit input stream and assembled-word output stream of the deserializer.
interface inv_bit_deserializer_if
  import inv_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_parity;
  logic             word_valid;
  logic             word_ready;

  // master drives bits and consumes words; slave is the deserializer itself
  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_parity, word_valid
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_parity, word_valid
  );

endinterface

// File: rtl/inv_deser_shift.sv
// Purpose: LSB-first shift register plus bit counter; flags the WIDTH-th accepted bit.
// Latency: word_complete/word_next are combinational in the accepting cycle.
// Backpressure: shifts only when accept is high; caller gates accept with its ready.
module inv_deser_shift
  import inv_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             bit_in,
  output logic [WIDTH-1:0] shift_q,
  output logic [WIDTH-1:0] word_next,
  output logic             word_complete
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  // New bits enter at the top, so the first accepted bit ends up in bit 0.
  assign word_next     = {bit_in, shift_q[WIDTH-1:1]};
  assign word_complete = accept && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (accept) begin
      shift_q <= word_next;
      cnt_q   <= word_complete ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/inv_bit_deserializer.sv
// Purpose: packs serial inverter-output bits into WIDTH-bit words with registered parity.
// Latency: word_valid rises 1 cycle after the last bit is accepted when the output is free.
// Backpressure: holds one completed word in the shifter (FULL, bit_ready=0) while the output stalls.
module inv_bit_deserializer
  import inv_deser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  inv_bit_deserializer_if.slave  bus
);

  deser_state_t     state_q, state_d;
  logic             accept;
  logic             out_free;
  logic             load;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_next;
  logic             word_complete;
  logic [WIDTH-1:0] word_q;
  logic             parity_q;
  logic             valid_q;

  assign bus.bit_ready   = (state_q == FILL);
  assign accept          = bus.bit_valid && bus.bit_ready;
  // Output register can take a new word if empty or being drained this cycle.
  assign out_free        = !valid_q || bus.word_ready;

  inv_deser_shift #(.WIDTH(WIDTH)) u_shift (
    .clk           (clk),
    .rst           (rst),
    .accept        (accept),
    .bit_in        (bus.bit_in),
    .shift_q       (shift_q),
    .word_next     (word_next),
    .word_complete (word_complete)
  );

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_word = word_next;
    unique case (state_q)
      FILL: begin
        if (word_complete) begin
          if (out_free) load = 1'b1;
          else          state_d = FULL;
        end
      end
      FULL: begin
        // shifter already holds the completed word and the counter is at 0
        if (out_free) begin
          load      = 1'b1;
          load_word = shift_q;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      word_q   <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        word_q   <= load_word;
        parity_q <= ^load_word;
        valid_q  <= 1'b1;
      end else if (bus.word_ready) begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_parity = parity_q;
  assign bus.word_valid  = valid_q;

endmodule

// File: tb/tb_inv_bit_deserializer.sv
// Directed bench for inv_bit_deserializer with a queue scoreboard and a negedge output monitor.
module tb_inv_bit_deserializer;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] w;
    logic         p;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t exp_q[$];

  inv_bit_deserializer_if #(.WIDTH(W)) bus ();

  inv_bit_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed word handshake pops and checks one expected word.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.word_valid && bus.word_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {24'h0, bus.word_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_out", {24'h0, bus.word_out}, {24'h0, e.w});
          chk("word_parity", {31'h0, bus.word_parity}, {31'h0, e.p});
        end
      end
    end
  end

  // Presents one bit and returns just after the edge that accepted it.
  task automatic send_bit(input logic b);
    int guard;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.bit_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("bit_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.bit_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int max_gap);
    for (int i = 0; i < W; i++) begin
      send_bit(w[i]);
      if (max_gap > 0 && i < W - 1) idle($urandom_range(0, max_gap));
    end
    bus.bit_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_word_valid", {31'h0, bus.word_valid}, 32'd0);
    chk("rst_word_out", {24'h0, bus.word_out}, 32'd0);
    chk("rst_word_parity", {31'h0, bus.word_parity}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("bit_ready_after_rst", {31'h0, bus.bit_ready}, 32'd1);

    // 0x4D back-to-back, single-cycle valid pulse
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    exp_q.push_back('{w: 8'h4D, p: 1'b0});
    v = 8'h4D;
    send_word(v, 0);
    @(negedge clk);
    chk("4d_valid_cycle1", {31'h0, bus.word_valid}, 32'd1);
    chk("4d_word", {24'h0, bus.word_out}, 32'h4D);
    @(negedge clk);
    chk("4d_valid_cycle2", {31'h0, bus.word_valid}, 32'd0);

    // 0xFF then 0x01 under stall: second word parks in FULL
    @(posedge clk);
    #1;
    bus.word_ready = 1'b0;
    exp_q.push_back('{w: 8'hFF, p: 1'b0});
    exp_q.push_back('{w: 8'h01, p: 1'b1});
    v = 8'hFF;
    send_word(v, 0);
    v = 8'h01;
    send_word(v, 0);
    @(negedge clk);
    chk("full_bit_ready", {31'h0, bus.bit_ready}, 32'd0);
    chk("full_hold_valid", {31'h0, bus.word_valid}, 32'd1);
    chk("full_hold_word", {24'h0, bus.word_out}, 32'hFF);
    @(posedge clk);
    #1;
    bus.word_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("drain_word", {24'h0, bus.word_out}, 32'h01);
    chk("drain_parity", {31'h0, bus.word_parity}, 32'd1);
    chk("drain_bit_ready", {31'h0, bus.bit_ready}, 32'd1);

    // 0xA5 with random idle gaps, no extra words
    @(posedge clk);
    #1;
    exp_q.push_back('{w: 8'hA5, p: 1'b0});
    v = 8'hA5;
    send_word(v, 3);
    idle(6);
    chk("a5_no_extra", exp_q.size(), 32'd0);

    // Partial word discarded by reset
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.bit_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("valid_in_rst", {31'h0, bus.word_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back('{w: 8'h3C, p: 1'b0});
    v = 8'h3C;
    send_word(v, 0);
    idle(4);
    chk("3c_no_extra", exp_q.size(), 32'd0);

    // Last bit of 0x34 lands in the cycle 0x12 drains: no FULL entry
    bus.word_ready = 1'b0;
    exp_q.push_back('{w: 8'h12, p: 1'b0});
    exp_q.push_back('{w: 8'h34, p: 1'b1});
    v = 8'h12;
    send_word(v, 0);
    v = 8'h34;
    for (int i = 0; i < W - 1; i++) send_bit(v[i]);
    bus.word_ready = 1'b1;
    send_bit(v[W-1]);
    bus.bit_valid = 1'b0;
    @(negedge clk);
    chk("same_cycle_word", {24'h0, bus.word_out}, 32'h34);
    chk("same_cycle_valid", {31'h0, bus.word_valid}, 32'd1);
    chk("same_cycle_bit_ready", {31'h0, bus.bit_ready}, 32'd1);

    idle(5);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("final_valid_low", {31'h0, bus.word_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
